// File: rtl/aes_pkg.sv
// Shared AES types for the decryption datapath. A column is four bytes with
// row 0 in the most significant byte, and a state is four such columns.
package aes_pkg;

  localparam int AES_BLOCK_W  = 128;
  localparam int AES_COL_W    = 32;
  localparam int AES_NUM_COLS = AES_BLOCK_W / AES_COL_W;

  typedef logic [7:0]                   byte_t;
  typedef byte_t [3:0]                  col_t;
  typedef col_t  [AES_NUM_COLS-1:0]     state_t;

  // Source column for row r of output column c: (c - r) mod 4, via 2-bit wrap.
  function automatic logic [1:0] src_col(input logic [1:0] c, input logic [1:0] r);
    return c - r;
  endfunction

endpackage

// File: rtl/reverse_sbox.sv
// AES inverse S-box: 8-bit in, 8-bit out, purely combinational table lookup.
// Only compiled when REVERSE_SUB_BYTES_EN is defined.
`ifdef REVERSE_SUB_BYTES_EN
module reverse_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign o_byte = INV_SBOX[i_byte];

endmodule
`endif

// File: rtl/reverse_shift_rows_buffer.sv
// Column-serial inverse ShiftRows with ping-pong state banks. Define
// REVERSE_SUB_BYTES_EN to fuse inverse SubBytes onto the output lanes.
module reverse_shift_rows_buffer
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_COL_W-1:0] in_col,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_COL_W-1:0] out_col,
  output logic                 busy
);

  state_t     r_bank [2];
  logic [1:0] r_full;
  logic [1:0] w_full_next;
  logic       r_wr_bank;
  logic       r_rd_bank;
  logic [1:0] r_wr_col;
  logic [1:0] r_rd_col;
  logic       w_in_fire;
  logic       w_out_fire;
  logic       w_fill_done;
  logic       w_drain_done;
  byte_t      w_lane [4];

  assign in_ready     = !r_full[r_wr_bank];
  assign out_valid    = r_full[r_rd_bank];
  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = out_valid && out_ready;
  assign w_fill_done  = w_in_fire && (r_wr_col == 2'd3);
  assign w_drain_done = w_out_fire && (r_rd_col == 2'd3);
  assign busy         = (|r_full) || (r_wr_col != 2'd0);

  // Fill and drain always target different banks, so both updates can land together.
  always_comb begin
    w_full_next = r_full;
    if (w_fill_done)  w_full_next[r_wr_bank] = 1'b1;
    if (w_drain_done) w_full_next[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_col  <= 2'd0;
      r_rd_col  <= 2'd0;
    end else begin
      r_full <= w_full_next;
      if (w_in_fire) begin
        r_wr_col <= r_wr_col + 2'd1;
        if (w_fill_done) r_wr_bank <= ~r_wr_bank;
      end
      if (w_out_fire) begin
        r_rd_col <= r_rd_col + 2'd1;
        if (w_drain_done) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) r_bank[r_wr_bank][r_wr_col] <= in_col;
  end

  // Row r of the output column reads bank column (c - r) mod 4; byte index 3 is row 0.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam logic [1:0] ROW = 2'(g);
    byte_t w_src;
    assign w_src = r_bank[r_rd_bank][src_col(r_rd_col, ROW)][3-g];
`ifdef REVERSE_SUB_BYTES_EN
    reverse_sbox u_sbox (
      .i_byte (w_src),
      .o_byte (w_lane[g])
    );
`else
    assign w_lane[g] = w_src;
`endif
  end

  assign out_col = out_valid ? {w_lane[0], w_lane[1], w_lane[2], w_lane[3]} : '0;

endmodule

// File: tb/tb_reverse_shift_rows_buffer.sv
// Directed bench for reverse_shift_rows_buffer (default build, no inverse S-box).
module tb_reverse_shift_rows_buffer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_col;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_col;
  logic        busy;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic [31:0] inCol;
    logic [31:0] expOut;
  } vec_t;

  vec_t vectors [4];

  reverse_shift_rows_buffer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] c, input logic rdy);
    in_valid  = v;
    in_col    = c;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Byte-wise XOR with the same value in every lane commutes with the row shift.
  function automatic logic [31:0] laneMask(input int k);
    logic [7:0] m;
    m = 8'(k * 16);
    return {m, m, m, m};
  endfunction

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Fill one state from the table, then drain it with out_ready high.
  task automatic fillAndDrain(input string tag);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, vectors[i].inCol, 1'b1);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      if (i == 3) checkOutput({tag, "_no_early_valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput({tag, "_latency_valid"}, 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_out_col"}, out_col, vectors[i].expOut);
      tick();
    end
    checkOutput({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vectors[0] = '{inCol: 32'h00010203, expOut: 32'h000d0a07};
    vectors[1] = '{inCol: 32'h04050607, expOut: 32'h04010e0b};
    vectors[2] = '{inCol: 32'h08090a0b, expOut: 32'h0805020f};
    vectors[3] = '{inCol: 32'h0c0d0e0f, expOut: 32'h0c090603};

    reset_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #2 reset_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_col", out_col, 32'h0);
    reset_n = 1'b1;
    tick();

    fillAndDrain("basic");

    // Backpressure: two states fill both banks, the ninth column must stall.
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, vectors[i % 4].inCol ^ laneMask(i / 4), 1'b0);
      checkOutput("bp_in_ready", 32'(in_ready), (i < 8) ? 32'd1 : 32'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_hold_col", out_col, 32'h000d0a07);
      checkOutput("bp_stall", 32'(in_ready), 32'd0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("bp_drain_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_drain_col", out_col, vectors[i % 4].expOut ^ laneMask(i / 4));
      tick();
    end
    checkOutput("bp_empty", 32'(out_valid), 32'd0);
    checkOutput("bp_busy", 32'(busy), 32'd0);

    // Streaming: three states with valid/ready held high, one column per cycle.
    doReset();
    begin
      int inIdx = 0;
      int outIdx = 0;
      int firstN = -1;
      int lastN = -1;
      for (int n = 0; n < 20; n++) begin
        if (out_valid) begin
          checkOutput("stream_col", out_col, vectors[outIdx % 4].expOut ^ laneMask(outIdx / 4));
          if (firstN < 0) firstN = n;
          lastN = n;
          outIdx++;
        end
        if (n == 8) begin
          checkOutput("simul_out_valid", 32'(out_valid), 32'd1);
          checkOutput("simul_next_col", out_col, vectors[0].expOut ^ laneMask(1));
        end
        if (inIdx < 12) begin
          applyStimulus(1'b1, vectors[inIdx % 4].inCol ^ laneMask(inIdx / 4), 1'b1);
          checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
          inIdx++;
        end else begin
          applyStimulus(1'b0, 32'h0, 1'b1);
        end
        tick();
      end
      checkOutput("stream_count", 32'(outIdx), 32'd12);
      checkOutput("stream_first", 32'(firstN), 32'd4);
      checkOutput("stream_last", 32'(lastN), 32'd15);
    end

    // Reset mid-fill: two columns in, then a fresh state must come out intact.
    doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'hdeadbeef ^ 32'(i), 1'b1);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("midfill_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midfill_busy", 32'(busy), 32'd0);
    checkOutput("midfill_valid", 32'(out_valid), 32'd0);
    checkOutput("midfill_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    fillAndDrain("after_fill_rst");

    // Reset mid-drain: out_valid must drop without waiting for a clock edge.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, vectors[i].inCol, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("middrain_col1", out_col, vectors[1].expOut);
    reset_n = 1'b0;
    #1;
    checkOutput("middrain_valid", 32'(out_valid), 32'd0);
    checkOutput("middrain_col", out_col, 32'h0);
    checkOutput("middrain_busy", 32'(busy), 32'd0);
    tick();
    reset_n = 1'b1;
    fillAndDrain("after_drain_rst");

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
